// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver.
// Captures one byte per rising edge of rx_done into a circular FIFO and
// presents the head entry first-word-fall-through. Tracks occupancy, a sticky
// overflow flag and a saturating dropped-byte counter.
// Note: rst_n is active-high despite its name (1 = reset).
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_done,
    input  logic              rd_en,
    input  logic              clr_ovf,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [7:0]        drop_cnt
);

    localparam int CW = ADDR_W + 1;
    localparam logic [ADDR_W:0] CNT_FULL = CW'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE  = CW'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              rx_done_q;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;

    logic wr_stb;
    logic rd_acc;
    logic wr_acc;
    logic drop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_FULL);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;
    assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];

    // A full FIFO still takes a write when a read frees the head slot in the same cycle.
    assign wr_stb = rx_done & ~rx_done_q;
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_stb & (~full | rd_acc);
    assign drop   = wr_stb & full & ~rd_acc;

    // Next-state for pointers, occupancy and overflow statistics; clear beats a same-cycle drop.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (clr_ovf) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // Control registers; rx_done_q resets high so a done level held across reset is not captured.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rx_done_q  <= 1'b1;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rx_done_q  <= rx_done;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= rx_data;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based reference model plus a scoreboard
// monitor that checks every byte the FIFO hands out.
module tb_uart_rx_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] rx_data;
    logic              rx_done;
    logic              rd_en;
    logic              clr_ovf;
    logic [DATA_W-1:0] rd_data;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic [7:0]        drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    byte unsigned ref_q[$];
    byte unsigned exp_q[$];
    bit           m_prev_done;
    bit           m_ovf;
    int           m_drop;

    uart_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .rd_en    (rd_en),
        .clr_ovf  (clr_ovf),
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, int act, int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, expv, expv, $time);
        end
    endfunction

    // Monitor: whenever the DUT offers a byte that is being consumed, compare to scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b0 && rd_en === 1'b1 && empty === 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_read_data", int'(rd_data), -1);
            end else begin
                chk("read_data", int'(rd_data), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic check_state(string tag);
        int sz;
        sz = ref_q.size();
        chk({tag, ".count"}, int'(count), sz);
        chk({tag, ".empty"}, int'(empty), (sz == 0) ? 1 : 0);
        chk({tag, ".full"}, int'(full), (sz == DEPTH) ? 1 : 0);
        chk({tag, ".overflow"}, int'(overflow), int'(m_ovf));
        chk({tag, ".drop_cnt"}, int'(drop_cnt), m_drop);
        chk({tag, ".rd_data"}, int'(rd_data), (sz == 0) ? 0 : int'(ref_q[0]));
    endtask

    // One clock cycle of stimulus; the model describes what the coming edge must do.
    task automatic cycle(bit done, byte unsigned data, bit rd, bit clr);
        bit wr_stb;
        bit rd_ok;
        rx_done = done;
        rx_data = data;
        rd_en   = rd;
        clr_ovf = clr;
        wr_stb = done && !m_prev_done;
        m_prev_done = done;
        rd_ok = rd && (ref_q.size() > 0);
        if (rd_ok) exp_q.push_back(ref_q.pop_front());
        if (wr_stb) begin
            if (ref_q.size() < DEPTH) begin
                ref_q.push_back(data);
            end else if (!clr) begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end
        end
        if (clr) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(byte unsigned data);
        cycle(1'b1, data, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic read_n(int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        ref_q.delete();
        m_prev_done = 1'b1;
        m_ovf       = 1'b0;
        m_drop      = 0;
    endtask

    initial begin
        rst_n   = 1'b1;
        rx_done = 1'b1;
        rx_data = 8'h3C;
        rd_en   = 1'b0;
        clr_ovf = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_state("in_reset");
        rst_n = 1'b0;

        // rx_done held high across reset release must not be captured
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        check_state("done_high_after_reset");
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // long done pulse gives exactly one write
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        check_state("long_pulse");
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("long_pulse.rd_data_A5", int'(rd_data), 8'hA5);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check_state("after_single_read");

        // fill, overflow by one, drain in order
        for (int i = 0; i < 16; i++) write_byte(byte'(i));
        check_state("filled");
        write_byte(8'h55);
        check_state("overflow_one");
        chk("overflow_one.drop_cnt_1", int'(drop_cnt), 1);
        read_n(17);
        check_state("drained");

        // simultaneous write and read while full
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) write_byte(byte'($urandom_range(0, 255)));
        check_state("refilled");
        cycle(1'b1, 8'h77, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check_state("full_wr_rd");
        chk("full_wr_rd.tail_77", int'(ref_q[DEPTH-1]), 8'h77);
        read_n(16);
        check_state("drained2");

        // pointer wrap-around
        for (int i = 0; i < 10; i++) write_byte(byte'($urandom_range(0, 255)));
        read_n(10);
        for (int i = 0; i < 12; i++) write_byte(byte'(8'h20 + i));
        check_state("wrap_written");
        read_n(12);
        check_state("wrap_drained");

        // randomized traffic, including read-while-empty and clear/drop collisions
        for (int i = 0; i < 600; i++) begin
            cycle(bit'($urandom_range(0, 1)), byte'($urandom_range(0, 255)),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 31) == 0);
            check_state("random");
        end
        read_n(DEPTH);
        check_state("random_drained");

        // saturating drop counter and clear
        for (int i = 0; i < 16; i++) write_byte(byte'($urandom_range(0, 255)));
        for (int i = 0; i < 300; i++) write_byte(byte'($urandom_range(0, 255)));
        check_state("saturated");
        chk("saturated.drop_cnt_255", int'(drop_cnt), 255);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check_state("cleared");

        // asynchronous reset mid-stream
        read_n(5);
        write_byte(8'h99);
        #3;
        rst_n = 1'b1;
        model_reset();
        #1;
        chk("async_reset.count", int'(count), 0);
        chk("async_reset.empty", int'(empty), 1);
        rx_done = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        check_state("post_reset_done_high");
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        write_byte(8'h42);
        check_state("post_reset_write");
        read_n(2);
        check_state("final");
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer directly downstream of the UART RS-232 receiver.
- Captures each completed byte on a rising edge of the receiver's done pulse and stores it in a circular FIFO.
- Presents bytes first-word-fall-through to the consuming logic (command decoder / display).
- Reports occupancy and sticky overflow, and counts dropped bytes.

Parameters:
- DATA_W, 8, byte width; matches receiver output.
- DEPTH, 16, FIFO entries; must be a power of 2, at least 2.
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  input  1  system clock; the only clock.
- rst_n  input  1  reset, asynchronous and active-high (1 = reset) despite the name.
- rx_data  input  DATA_W  byte from receiver; valid while rx_done high.
- rx_done  input  1  receiver done flag; may stay high for many clk cycles.
- rd_en  input  1  consumer pop request.
- clr_ovf  input  1  clears overflow and drop_cnt.
- rd_data  output  DATA_W  head entry (FWFT); 0 when empty.
- empty  output  1  no entries.
- full  output  1  count == DEPTH.
- count  output  ADDR_W+1  occupancy, 0..DEPTH.
- overflow  output  1  sticky: a byte was dropped because FIFO full.
- drop_cnt  output  8  dropped-byte count, saturates at 255.

Behaviour:
- Decided: one clock; reset is asynchronous and active-high. Reset is applied on assertion regardless of clk.
- Reset values:
  - wr_ptr = rd_ptr = 0, count = 0.
  - empty = 1, full = 0, rd_data = 0.
  - overflow = 0, drop_cnt = 0.
  - Edge register rx_done_q = 1, so an rx_done already high at reset release is not captured.
- Memory contents are not reset.
- Write strobe: wr_stb = rx_done & ~rx_done_q; rx_done_q <= rx_done every cycle.
  - Exactly one write per rx_done high period, however long it lasts.
  - rx_data is sampled on the same edge that evaluates wr_stb.
- Write:
  - On wr_stb with not full (or full with a simultaneous accepted read): mem[wr_ptr] <= rx_data, wr_ptr <= wr_ptr+1.
  - Latency: empty deasserts and count increments on that same clk edge.
- Read:
  - Accepted when rd_en & ~empty: rd_ptr <= rd_ptr+1.
  - rd_data is combinational mem[rd_ptr], forced to 0 while empty.
  - rd_en while empty is ignored; no pointer or count change.
- Pointers wrap modulo DEPTH (natural ADDR_W rollover).
- count update per cycle: +1 on write only, -1 on read only, unchanged on both or neither.
- full and empty are decoded from count.
- Simultaneous events:
  - wr_stb & accepted read while full: both happen, count stays DEPTH, no overflow.
  - wr_stb & rd_en while empty: write happens, read ignored, count becomes 1.
- Overflow:
  - wr_stb while full with no accepted read: byte discarded, pointers unchanged.
  - overflow <= 1; drop_cnt <= drop_cnt+1, held at 255.
- clr_ovf:
  - Clears overflow and drop_cnt next edge.
  - If a drop occurs in the same cycle, clr_ovf wins for overflow; drop_cnt becomes 1 and overflow becomes 1 on the following edge only if another drop occurs. In short: clear has priority and the same-cycle drop is lost from statistics.
- Reset mid-operation: all entries discarded (count = 0) immediately on assertion.
  - Any rx_done still high after release is ignored until it falls and rises again.
- No FSM states beyond FIFO occupancy; all outputs are registered except rd_data, empty and full (decoded from registers).

Test Plan:
- Reset release with rx_done held high for 5 cycles -> count stays 0, empty = 1, no write.
- rx_done pulse high for 20 cycles with rx_data = 8'hA5 -> exactly one write; next cycle count = 1, rd_data = 8'hA5; pulse rd_en once -> empty = 1, rd_data = 0.
- Write 16 bytes 8'h00..8'h0F -> full = 1, count = 16; 17th byte 8'h55 -> overflow = 1, drop_cnt = 1; reads return 8'h00..8'h0F in order; 8'h55 is never output.
- With FIFO full, assert wr_stb (8'h77) and rd_en in the same cycle -> count stays 16, overflow stays 0, 8'h77 is read last.
- Wrap-around: 10 writes, 10 reads, then 12 writes with values 8'h20..8'h2B -> reads return 8'h20..8'h2B in order; count returns to 0.
- 300 drops while full -> drop_cnt = 255 (saturated); clr_ovf pulse -> overflow = 0, drop_cnt = 0 next cycle; assert rst_n mid-stream -> count = 0 asynchronously.
